// File: rtl/spi_bridge_pkg.sv
// Shared constants and helpers for the SPI system-clock bridge.
package spi_bridge_pkg;

    localparam int          SYNC_STAGES  = 2;
    localparam int          RXRDY_STAGES = 3;
    localparam logic [63:0] TX_IDLE_DEF  = '1;

    // One extra pointer bit separates a full FIFO from an empty one.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Purpose: multi-flop synchronizer for one asynchronous bit into clk.
// Latency: STAGES clk cycles.
// Backpressure: none, free-running.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= {STAGES{RST_VAL}};
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d};
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/spi_sys_bridge.sv
// Purpose: clk-domain side of the SPI slave core: RX word FIFO, TX hold/refill, frame pulses.
// Latency: rxRdy fall to rxValid 4-5 clk; txLoad rise to refilled txData 3-4 clk.
// Backpressure: rxValid/rxAck on read (full FIFO drops and flags); txReady low while hold is occupied.
module spi_sys_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                  DATA_WDT = 8,
    parameter int                  RX_DEPTH = 4,
    parameter logic [DATA_WDT-1:0] TX_IDLE  = TX_IDLE_DEF[DATA_WDT-1:0]
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ssel,
    input  logic                rxRdy,
    input  logic [DATA_WDT-1:0] rxData,
    input  logic                txLoad,
    output logic [DATA_WDT-1:0] txData,
    output logic                rxValid,
    output logic [DATA_WDT-1:0] rxWord,
    input  logic                rxAck,
    input  logic [DATA_WDT-1:0] txWord,
    input  logic                txValid,
    output logic                txReady,
    output logic                rxOverflow,
    output logic                txUnderrun,
    output logic                frameStart,
    output logic                frameEnd
);

    localparam int PW = fifo_ptr_w(RX_DEPTH);
    localparam int AW = PW - 1;

    logic ssel_s, rxrdy_s, txload_s;
    logic ssel_q, rxrdy_q, txload_q;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .reset(reset), .d(ssel), .q(ssel_s)
    );
    // One stage deeper than ssel so a frame abort is always seen before the rxRdy fall it causes.
    sync_ff #(.STAGES(RXRDY_STAGES), .RST_VAL(1'b0)) u_sync_rxrdy (
        .clk(clk), .reset(reset), .d(rxRdy), .q(rxrdy_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_txload (
        .clk(clk), .reset(reset), .d(txLoad), .q(txload_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssel_q   <= 1'b1;
            rxrdy_q  <= 1'b0;
            txload_q <= 1'b0;
        end else begin
            ssel_q   <= ssel_s;
            rxrdy_q  <= rxrdy_s;
            txload_q <= txload_s;
        end
    end

    logic word_evt, txload_rise;

    assign word_evt    = rxrdy_q & ~rxrdy_s & ~ssel_s & ~ssel_q;
    assign txload_rise = txload_s & ~txload_q;
    assign frameStart  = ssel_q & ~ssel_s;
    assign frameEnd    = ~ssel_q & ssel_s;

    logic [DATA_WDT-1:0] mem_q [RX_DEPTH];
    logic [PW-1:0]       wptr_q, rptr_q;
    logic                fifo_full, fifo_pop, fifo_wr;

    assign rxValid    = (wptr_q != rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rxWord     = mem_q[rptr_q[AW-1:0]];
    assign fifo_pop   = rxValid & rxAck;
    assign fifo_wr    = word_evt & (~fifo_full | fifo_pop);
    assign rxOverflow = word_evt & fifo_full & ~fifo_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem_q[wptr_q[AW-1:0]] <= rxData;
                wptr_q                <= wptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    logic [DATA_WDT-1:0] tx_data_q, tx_data_d, hold_q, hold_d;
    logic                tx_pend_q, tx_pend_d, hold_full_q, hold_full_d;
    logic                tx_accept;

    assign txReady   = ~hold_full_q;
    assign tx_accept = txValid & ~hold_full_q;
    assign txData    = tx_data_q;

    // A load edge only ever sees the old hold; a same-cycle write lands after it.
    always_comb begin
        tx_data_d   = tx_data_q;
        tx_pend_d   = tx_pend_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txUnderrun  = 1'b0;
        if (txload_rise) begin
            if (hold_full_q) begin
                tx_data_d   = hold_q;
                tx_pend_d   = 1'b1;
                hold_full_d = 1'b0;
            end else begin
                tx_data_d   = TX_IDLE;
                tx_pend_d   = 1'b0;
                txUnderrun  = ~ssel_s;
            end
        end else if (!tx_pend_q && hold_full_q) begin
            tx_data_d   = hold_q;
            tx_pend_d   = 1'b1;
            hold_full_d = 1'b0;
        end
        if (tx_accept) begin
            hold_d      = txWord;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_q   <= TX_IDLE;
            tx_pend_q   <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            tx_data_q   <= tx_data_d;
            tx_pend_q   <= tx_pend_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_spi_sys_bridge.sv
// Scoreboard bench: a simple core model drives the async strobes; monitors check RX words, TX loads and pulses.
module tb_spi_sys_bridge;

    localparam int BIT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ssel, rxRdy, txLoad, rxAck, txValid;
    logic [7:0] rxData, txWord;
    logic [7:0] txData, rxWord;
    logic       rxValid, txReady, rxOverflow, txUnderrun, frameStart, frameEnd;

    always #5 clk = ~clk;

    spi_sys_bridge #(.DATA_WDT(8), .RX_DEPTH(4), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .reset(reset), .ssel(ssel), .rxRdy(rxRdy), .rxData(rxData),
        .txLoad(txLoad), .txData(txData), .rxValid(rxValid), .rxWord(rxWord),
        .rxAck(rxAck), .txWord(txWord), .txValid(txValid), .txReady(txReady),
        .rxOverflow(rxOverflow), .txUnderrun(txUnderrun),
        .frameStart(frameStart), .frameEnd(frameEnd)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    int  cnt_fs = 0, cnt_fe = 0, cnt_ov = 0, cnt_ur = 0;
    int  s_fs, s_fe, s_ov, s_ur;
    time t_fall = 0, t_rise = 0;

    logic [7:0] rxw[5];
    logic [7:0] txe[5];
    logic [7:0] wr[2];
    int         cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rxValid && rxAck) begin
            if (rx_exp.size() == 0) check("rx_unexpected_word", {24'd0, rxWord}, 32'hFFFF_FFFF);
            else                   check("rx_word", {24'd0, rxWord}, {24'd0, rx_exp.pop_front()});
        end
    end

    always @(posedge txLoad) begin
        if (tx_exp.size() == 0) check("tx_unexpected_load", {24'd0, txData}, 32'hFFFF_FFFF);
        else                   check("tx_word_latched", {24'd0, txData}, {24'd0, tx_exp.pop_front()});
    end

    always @(negedge clk) begin
        if (!reset) begin
            cnt_fs += int'(frameStart);
            cnt_fe += int'(frameEnd);
            cnt_ov += int'(rxOverflow);
            cnt_ur += int'(txUnderrun);
        end
    end

    always @(negedge rxRdy) t_fall = $time;
    always @(posedge rxValid) t_rise = $time;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        s_fs = cnt_fs; s_fe = cnt_fe; s_ov = cnt_ov; s_ur = cnt_ur;
    endtask

    task automatic check_pulses(input string tag, input int fs, input int fe, input int ov, input int ur);
        check({tag, "_frameStart"}, cnt_fs - s_fs, fs);
        check({tag, "_frameEnd"},   cnt_fe - s_fe, fe);
        check({tag, "_rxOverflow"}, cnt_ov - s_ov, ov);
        check({tag, "_txUnderrun"}, cnt_ur - s_ur, ur);
    endtask

    task automatic tx_write(input logic [7:0] w);
        bit ok = 1'b0;
        txWord  = w;
        txValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = txReady;
            @(posedge clk);
            #2;
        end
        txValid = 1'b0;
        if (!ok) check("tx_write_timeout", 0, 1);
    endtask

    task automatic drain(output int c);
        rxAck = 1'b1;
        c = 0;
        while (rxValid && c < 20) begin
            @(posedge clk);
            #2;
            c++;
        end
        rxAck = 1'b0;
    endtask

    // Core model: the word-1 load happens as select arrives, later loads at each word start.
    task automatic run_frame(input int n, input logic [7:0] rw[5], input logic [7:0] te[5],
                             input int n_wr, input logic [7:0] ww[2]);
        tx_exp.push_back(te[0]);
        txLoad = 1'b1;
        for (int i = 0; i < n_wr; i++) tx_write(ww[i]);
        tick(8);
        txLoad = 1'b0;
        tick(4);
        ssel = 1'b0;
        tick(BIT);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                tx_exp.push_back(te[k]);
                txLoad = 1'b1;
            end
            tick(BIT);
            rxRdy = 1'b1;
            tick(3 * BIT);
            txLoad = 1'b0;
            tick(4 * BIT);
            rxData = rw[k];
            rxRdy  = 1'b0;
        end
        tick(BIT);
        ssel = 1'b1;
        tick(8);
    endtask

    initial begin
        reset = 1'b1; ssel = 1'b1; rxRdy = 1'b0; txLoad = 1'b0; rxData = 8'h00;
        rxAck = 1'b0; txValid = 1'b0; txWord = 8'h00;
        wr = '{8'h00, 8'h00};
        tick(3);
        check("reset_txData", {24'd0, txData}, 32'hFF);
        check("reset_txReady", {31'd0, txReady}, 1);
        check("reset_rxValid", {31'd0, rxValid}, 0);
        check("reset_rxWord", {24'd0, rxWord}, 0);
        check("reset_pulses", {28'd0, frameStart, frameEnd, rxOverflow, txUnderrun}, 0);
        reset = 1'b0;
        tick(3);

        // Single word
        snap();
        rx_exp.push_back(8'hA5);
        rxw = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        txe = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(1, rxw, txe, 0, wr);
        check("single_rxValid", {31'd0, rxValid}, 1);
        check("single_latency_ok", {31'd0, ((t_rise - t_fall + 9) / 10) inside {4, 5}}, 1);
        check_pulses("single", 1, 1, 0, 0);
        drain(cyc);
        check("single_drain_cycles", cyc, 1);

        // Overflow: fifth word dropped, first four kept in order
        snap();
        for (int i = 1; i <= 4; i++) rx_exp.push_back(8'(i));
        rxw = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame(5, rxw, txe, 0, wr);
        check_pulses("overflow", 1, 1, 1, 4);
        drain(cyc);
        check("overflow_drain_cycles", cyc, 4);
        check("overflow_queue_empty", rx_exp.size(), 0);

        // Underrun: only 0x55 primed for a two-word frame
        tx_write(8'h55);
        tick(4);
        check("underrun_primed_txData", {24'd0, txData}, 32'h55);
        snap();
        rx_exp.push_back(8'h12);
        rx_exp.push_back(8'h34);
        rxw = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
        txe = '{8'h55, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_frame(2, rxw, txe, 0, wr);
        check_pulses("underrun", 1, 1, 0, 1);
        drain(cyc);

        // TX stream: 0x3C primed, 0xC3 and 0xE7 written after the first load
        tx_write(8'h3C);
        tick(4);
        snap();
        rx_exp.push_back(8'h9A);
        rx_exp.push_back(8'hBC);
        rxw = '{8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00};
        txe = '{8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00};
        wr  = '{8'hC3, 8'hE7};
        run_frame(2, rxw, txe, 2, wr);
        check_pulses("stream", 1, 1, 0, 0);
        check("stream_next_txData", {24'd0, txData}, 32'hE7);
        drain(cyc);

        // Aborted word: select drops after 6 bits
        snap();
        tx_exp.push_back(8'hE7);
        txLoad = 1'b1;
        tick(8);
        txLoad = 1'b0;
        tick(4);
        ssel = 1'b0;
        tick(BIT);
        rxRdy = 1'b1;
        tick(5 * BIT);
        rxData = 8'h77;
        ssel   = 1'b1;
        rxRdy  = 1'b0;
        tick(12);
        check("abort_rxValid", {31'd0, rxValid}, 0);
        check_pulses("abort", 1, 1, 0, 0);

        // Async reset mid-frame with RX words queued and hold full
        rxw = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
        txe = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        wr  = '{8'h00, 8'h00};
        run_frame(2, rxw, txe, 0, wr);
        check("prereset_rxValid", {31'd0, rxValid}, 1);
        tx_write(8'hA1);
        tick(3);
        tx_write(8'hB2);
        tick(2);
        check("prereset_txReady", {31'd0, txReady}, 0);
        check("prereset_txData", {24'd0, txData}, 32'hA1);
        ssel = 1'b0;
        tick(4);
        reset = 1'b1;
        #1;
        check("midreset_rxValid", {31'd0, rxValid}, 0);
        check("midreset_txReady", {31'd0, txReady}, 1);
        check("midreset_txData", {24'd0, txData}, 32'hFF);
        check("midreset_rxWord", {24'd0, rxWord}, 0);
        tick(2);
        ssel = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        check("postreset_rxValid", {31'd0, rxValid}, 0);
        check("tx_loads_all_seen", tx_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog_timeout reached=1 required=0");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
